// File: rtl/bsg_level_shift_up_down_sink_buffered.sv
// bsg_level_shift_up_down_sink_buffered
//   Sink-side (v1 domain) receiver of a level-shifted crossing. Raw v0 inputs
//   are forced to zero until v1_en_i has been held for a settle window. After
//   that, words are accepted into a 2-entry FIFO. Dropping v1_en_i
//   re-isolates the inputs and flushes the FIFO.
//
// Ports
//   clk_i        shared clock for v0 and v1 logic
//   reset_n_i    asynchronous active-low reset
//   v1_en_i      sink enable; low = isolate
//   v0_valid_i   raw source valid (may be X while isolated)
//   v0_data_i    raw source data  (may be X while isolated)
//   v0_ready_o   FIFO can take a word this cycle
//   v1_valid_o   FIFO head available
//   v1_data_o    FIFO head, zero when v1_valid_o=0
//   v1_ready_i   consumer takes the head this cycle
//   v1_active_o  isolation released (ACTIVE state)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready. v0_ready_o is a function of
// registered state only, so there is no combinational path from v1_ready_i.
module bsg_level_shift_up_down_sink_buffered #(
  parameter int width_p         = 128,
  parameter int settle_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v1_en_i,
  input  logic               v0_valid_i,
  input  logic [width_p-1:0] v0_data_i,
  output logic               v0_ready_o,
  output logic               v1_valid_o,
  output logic [width_p-1:0] v1_data_o,
  input  logic               v1_ready_i,
  output logic               v1_active_o
);

  localparam int cnt_w = (settle_cycles_p > 0) ? $clog2(settle_cycles_p + 1) : 1;
  localparam logic [cnt_w-1:0] settle_c = cnt_w'(settle_cycles_p);
  localparam logic [cnt_w-1:0] cnt_max_c = '1;

  typedef enum logic [1:0] {
    ST_ISOLATED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0] head_q, head_d;
  logic [width_p-1:0] tail_q, tail_d;
  logic [1:0]         count_q, count_d;

  logic               active;
  logic               flush;
  logic               g_valid;
  logic [width_p-1:0] g_data;
  logic               enq;
  logic               deq;

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_ISOLATED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ISOLATED: begin
        if (v1_en_i) begin
          if (settle_cycles_p == 0) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = cnt_w'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!v1_en_i) begin
          state_d = ST_ISOLATED;
          cnt_d   = '0;
        end else if (cnt_q == settle_c) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q != cnt_max_c) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_ACTIVE: begin
        if (!v1_en_i) begin
          state_d = ST_ISOLATED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ISOLATED;
        cnt_d   = '0;
      end
    endcase
  end

  // Isolation gates. Raw inputs never reach a register unless ACTIVE.
  assign active  = (state_q == ST_ACTIVE);
  assign g_valid = v0_valid_i & active;
  assign g_data  = v0_data_i & {width_p{active}};

  // Losing enable while ACTIVE flushes; nothing else commits on that edge.
  assign flush = active & ~v1_en_i;

  assign v0_ready_o  = active && (count_q != 2'd2);
  assign v1_valid_o  = (count_q != 2'd0);
  assign v1_data_o   = v1_valid_o ? head_q : '0;
  assign v1_active_o = active;

  assign enq = g_valid && v0_ready_o && !flush;
  assign deq = v1_valid_o && v1_ready_i && !flush;

  // FIFO storage
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // FIFO next state. head is always the oldest word; tail is only
  // meaningful when count=2.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (enq) begin
            head_d  = g_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (enq && deq) begin
            head_d = g_data;
          end else if (enq) begin
            tail_d  = g_data;
            count_d = 2'd2;
          end else if (deq) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (deq) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_level_shift_up_down_sink_buffered.sv
module tb_bsg_level_shift_up_down_sink_buffered;

  localparam int W  = 128;
  localparam int WZ = 8;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_n_i;
  always #5 clk_i = ~clk_i;

  // main DUT (settle_cycles_p = 4)
  logic         v1_en_i, v0_valid_i, v1_ready_i;
  logic [W-1:0] v0_data_i;
  logic         v0_ready_o, v1_valid_o, v1_active_o;
  logic [W-1:0] v1_data_o;

  bsg_level_shift_up_down_sink_buffered #(.width_p(W), .settle_cycles_p(4)) u_dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v1_en_i     (v1_en_i),
    .v0_valid_i  (v0_valid_i),
    .v0_data_i   (v0_data_i),
    .v0_ready_o  (v0_ready_o),
    .v1_valid_o  (v1_valid_o),
    .v1_data_o   (v1_data_o),
    .v1_ready_i  (v1_ready_i),
    .v1_active_o (v1_active_o)
  );

  // second DUT with a zero-length settle window
  logic          en_z, valid_z, ready_z;
  logic [WZ-1:0] data_z;
  logic          v0_ready_z, v1_valid_z, active_z;
  logic [WZ-1:0] v1_data_z;

  bsg_level_shift_up_down_sink_buffered #(.width_p(WZ), .settle_cycles_p(0)) u_dut_z (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v1_en_i     (en_z),
    .v0_valid_i  (valid_z),
    .v0_data_i   (data_z),
    .v0_ready_o  (v0_ready_z),
    .v1_valid_o  (v1_valid_z),
    .v1_data_o   (v1_data_z),
    .v1_ready_i  (ready_z),
    .v1_active_o (active_z)
  );

  typedef struct {
    logic         en;
    logic         valid;
    logic [W-1:0] data;
    logic         rdy;
    logic         exp_v0_ready;
    logic         exp_v1_valid;
    logic [W-1:0] exp_data;
    logic         exp_active;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic en, input logic valid, input logic [W-1:0] data,
                     input logic rdy, input logic er, input logic ev,
                     input logic [W-1:0] ed, input logic ea);
    vec_t v;
    v.en = en; v.valid = valid; v.data = data; v.rdy = rdy;
    v.exp_v0_ready = er; v.exp_v1_valid = ev; v.exp_data = ed; v.exp_active = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic er, input logic ev,
                            input logic [W-1:0] ed, input logic ea);
    check({tag, " v0_ready"},  W'(v0_ready_o),  W'(er));
    check({tag, " v1_valid"},  W'(v1_valid_o),  W'(ev));
    check({tag, " v1_data"},   v1_data_o,       ed);
    check({tag, " v1_active"}, W'(v1_active_o), W'(ea));
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [W-1:0] all1;

  initial begin
    all1 = '1;

    // reset with garbage on the raw v0 side
    reset_n_i  = 1'b0;
    v1_en_i    = 1'b0;
    v0_valid_i = 1'bx;
    v0_data_i  = 'x;
    v1_ready_i = 1'b0;
    en_z = 1'b0; valid_z = 1'b0; data_z = '0; ready_z = 1'b0;
    #12;
    check_main("reset", 1'b0, 1'b0, '0, 1'b0);
    tick();
    reset_n_i = 1'b1;

    // isolated: X and all-ones inputs must not leak
    v0_valid_i = 1'b1;
    tick();
    check_main("iso_x", 1'b0, 1'b0, '0, 1'b0);
    v0_data_i = all1;
    tick();
    check_main("iso_ones", 1'b0, 1'b0, '0, 1'b0);

    // settle window, inputs held hot to check the activating edge
    for (int i = 0; i < 4; i++) add(1, 1, all1, 0, 0, 0, 0, 0);
    add(1, 1, all1, 0, 1, 0, 0, 1);
    // streaming with consumer ready
    add(1, 1, 'h1, 1, 1, 1, 'h1, 1);
    add(1, 1, 'h2, 1, 1, 1, 'h2, 1);
    add(1, 1, 'h3, 1, 1, 1, 'h3, 1);
    add(1, 0, 'h0, 1, 1, 0, 'h0, 1);
    // fill, hold full, drain in order
    add(1, 1, 'hA, 0, 1, 1, 'hA, 1);
    add(1, 1, 'hB, 0, 0, 1, 'hA, 1);
    add(1, 1, 'hC, 0, 0, 1, 'hA, 1);
    add(1, 0, 'h0, 1, 1, 1, 'hB, 1);
    add(1, 0, 'h0, 1, 1, 0, 'h0, 1);
    // full with consumer ready: no bypass, offered word not taken
    add(1, 1, 'hD, 0, 1, 1, 'hD, 1);
    add(1, 1, 'hE, 0, 0, 1, 'hD, 1);
    add(1, 1, 'hF, 1, 1, 1, 'hE, 1);
    add(1, 0, 'h0, 1, 1, 0, 'h0, 1);
    // full, then enable dropped for one cycle: flush, then full resettle
    add(1, 1, 'h11, 0, 1, 1, 'h11, 1);
    add(1, 1, 'h22, 0, 0, 1, 'h11, 1);
    add(0, 1, 'h33, 1, 0, 0, 'h0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 'h44, 1, 0, 0, 'h0, 0);
    add(1, 1, 'h44, 0, 1, 0, 'h0, 1);
    // enable toggled during settle restarts the window
    add(0, 1, 'h55, 0, 0, 0, 'h0, 0);
    add(1, 1, 'h55, 0, 0, 0, 'h0, 0);
    add(1, 1, 'h55, 0, 0, 0, 'h0, 0);
    add(0, 1, 'h55, 0, 0, 0, 'h0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 'h55, 0, 0, 0, 'h0, 0);
    add(1, 1, 'h55, 0, 1, 0, 'h0, 1);
    // refill before the asynchronous reset
    add(1, 1, 'h66, 0, 1, 1, 'h66, 1);
    add(1, 1, 'h77, 0, 0, 1, 'h66, 1);

    foreach (vecs[i]) begin
      v1_en_i    = vecs[i].en;
      v0_valid_i = vecs[i].valid;
      v0_data_i  = vecs[i].data;
      v1_ready_i = vecs[i].rdy;
      tick();
      check_main($sformatf("row%0d", i), vecs[i].exp_v0_ready, vecs[i].exp_v1_valid,
                 vecs[i].exp_data, vecs[i].exp_active);
      check($sformatf("row%0d z_idle", i), W'({v0_ready_z, v1_valid_z, active_z}), W'(0));
    end

    // asynchronous reset mid-cycle with a full buffer
    #3;
    reset_n_i = 1'b0;
    #1;
    check_main("async_rst", 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check_main("rst_hold", 1'b0, 1'b0, '0, 1'b0);
    v1_en_i    = 1'b0;
    v0_valid_i = 1'b0;
    reset_n_i  = 1'b1;
    tick();
    check_main("post_rst", 1'b0, 1'b0, '0, 1'b0);

    // zero settle window: ACTIVE right after the first enabled edge
    en_z = 1'b1;
    tick();
    check("z_active", W'(active_z), W'(1));
    check("z_ready", W'(v0_ready_z), W'(1));
    check("z_valid0", W'(v1_valid_z), W'(0));
    valid_z = 1'b1;
    data_z  = 8'h5A;
    tick();
    check("z_valid1", W'(v1_valid_z), W'(1));
    check("z_data", W'(v1_data_z), W'(8'h5A));
    valid_z = 1'b0;
    en_z    = 1'b0;
    tick();
    check("z_flush_valid", W'(v1_valid_z), W'(0));
    check("z_flush_active", W'(active_z), W'(0));
    check("z_flush_data", W'(v1_data_z), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
